ram_burst_reader: RTL and testbench

RAM_BURST_READER -- requirements
Module: ram_burst_reader

---
 rtl/ram_burst_reader.sv | 160 ++++++++++++++++
 tb/tb_ram_burst_reader.sv | 249 ++++++++++++++++++++++++
 2 files changed

// File: rtl/ram_burst_reader.sv
// ram_burst_reader: reads a burst of bytes from an external RAM with an
// asynchronous read port and streams them out over a valid/ready interface.
// Optional feature macro: RAM_RD_CHECKSUM_EN. When it is defined, an XOR
// checksum beat is appended after the last data byte of every non-empty burst.
module ram_burst_reader #(
    parameter int ram_width = 8,
    parameter int add_bits  = 5
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [add_bits-1:0]   start_addr,
    input  logic [add_bits:0]     burst_len,
    output logic [add_bits-1:0]   address_r,
    input  logic [ram_width-1:0]  ram_data,
    output logic [ram_width-1:0]  tx_data,
    output logic                  tx_valid,
    input  logic                  tx_ready,
    output logic                  busy,
    output logic                  done
);

    localparam int depth = 2 ** add_bits;
    // Longest burst that still reads every location exactly once.
    localparam logic [add_bits:0] max_len = (add_bits + 1)'(depth);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        FETCH = 3'd1,
        SEND  = 3'd2,
        DONE  = 3'd3
`ifdef RAM_RD_CHECKSUM_EN
        , CSUM = 3'd4
`endif
    } state_t;

    state_t                 state_reg, state_next;
    logic [add_bits-1:0]    rd_ptr_reg, rd_ptr_next;
    logic [add_bits:0]      remain_reg, remain_next;
    logic [ram_width-1:0]   tx_data_reg, tx_data_next;
    logic                   tx_valid_reg, tx_valid_next;
`ifdef RAM_RD_CHECKSUM_EN
    logic [ram_width-1:0]   csum_reg, csum_next;
`endif

    logic handshake;

    assign handshake = tx_valid_reg & tx_ready;
    assign address_r = rd_ptr_reg;
    assign tx_data   = tx_data_reg;
    assign tx_valid  = tx_valid_reg;
    assign busy      = (state_reg != IDLE);
    assign done      = (state_reg == DONE);

    // State register; reset aborts any burst in flight.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // Datapath registers: read pointer, byte countdown, output holding stage.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_ptr_reg   <= '0;
            remain_reg   <= '0;
            tx_data_reg  <= '0;
            tx_valid_reg <= 1'b0;
`ifdef RAM_RD_CHECKSUM_EN
            csum_reg     <= '0;
`endif
        end else begin
            rd_ptr_reg   <= rd_ptr_next;
            remain_reg   <= remain_next;
            tx_data_reg  <= tx_data_next;
            tx_valid_reg <= tx_valid_next;
`ifdef RAM_RD_CHECKSUM_EN
            csum_reg     <= csum_next;
`endif
        end
    end

    // Next-state and datapath update; everything holds unless a state acts.
    always_comb begin
        state_next    = state_reg;
        rd_ptr_next   = rd_ptr_reg;
        remain_next   = remain_reg;
        tx_data_next  = tx_data_reg;
        tx_valid_next = tx_valid_reg;
`ifdef RAM_RD_CHECKSUM_EN
        csum_next     = csum_reg;
`endif
        case (state_reg)
            IDLE: begin
                if (start) begin
                    if (burst_len == '0) begin
                        // Empty burst: just signal completion.
                        state_next = DONE;
                    end else begin
                        rd_ptr_next = start_addr;
                        remain_next = (burst_len > max_len) ? max_len : burst_len;
`ifdef RAM_RD_CHECKSUM_EN
                        csum_next   = '0;
`endif
                        state_next  = FETCH;
                    end
                end
            end
            FETCH: begin
                // Capture the first byte; the pointer moves on to the next one.
                tx_data_next  = ram_data;
                tx_valid_next = 1'b1;
                rd_ptr_next   = rd_ptr_reg + 1'b1;
                state_next    = SEND;
            end
            SEND: begin
                if (handshake) begin
`ifdef RAM_RD_CHECKSUM_EN
                    csum_next = csum_reg ^ tx_data_reg;
`endif
                    if (remain_reg > 1) begin
                        // RAM already shows the next byte: one byte per cycle.
                        tx_data_next = ram_data;
                        rd_ptr_next  = rd_ptr_reg + 1'b1;
                        remain_next  = remain_reg - 1'b1;
                    end else begin
                        remain_next = '0;
`ifdef RAM_RD_CHECKSUM_EN
                        tx_data_next = csum_reg ^ tx_data_reg;
                        state_next   = CSUM;
`else
                        tx_valid_next = 1'b0;
                        state_next    = DONE;
`endif
                    end
                end
            end
`ifdef RAM_RD_CHECKSUM_EN
            CSUM: begin
                // Checksum beat is held until the consumer takes it.
                if (tx_ready) begin
                    tx_valid_next = 1'b0;
                    state_next    = DONE;
                end
            end
`endif
            DONE: begin
                tx_valid_next = 1'b0;
                state_next    = IDLE;
            end
            default: begin
                tx_valid_next = 1'b0;
                state_next    = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_ram_burst_reader.sv
// Testbench for ram_burst_reader: table-driven bursts, randomized bursts with
// random back-pressure, and hand-written reset/abort and checksum sequences.
module tb_ram_burst_reader;

    localparam int W = 8;
    localparam int A = 5;
    localparam int DEPTH = 32;

    logic          clk = 1'b0;
    logic          rst;
    logic          start;
    logic [A-1:0]  start_addr;
    logic [A:0]    burst_len;
    logic [A-1:0]  address_r;
    logic [W-1:0]  ram_data;
    logic [W-1:0]  tx_data;
    logic          tx_valid;
    logic          tx_ready;
    logic          busy;
    logic          done;

    logic [7:0]    mem [DEPTH];

    int checks = 0;
    int errors = 0;

    assign ram_data = mem[address_r];

    always #5 clk = ~clk;

    ram_burst_reader #(.ram_width(W), .add_bits(A)) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .start_addr (start_addr),
        .burst_len  (burst_len),
        .address_r  (address_r),
        .ram_data   (ram_data),
        .tx_data    (tx_data),
        .tx_valid   (tx_valid),
        .tx_ready   (tx_ready),
        .busy       (busy),
        .done       (done)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    typedef struct {
        int addr;
        int len;
        int mode;       // 0: always ready, 1: random ready, 2: 5-cycle stall on byte 2
        int exp_count;  // data bytes expected on the stream
    } vec_t;

    // One burst, checked against a reference computed directly from the rules.
    task automatic run_burst(input int addr, input int len, input int mode, input int exp_count);
        logic [7:0] exp_q[$];
        logic [7:0] got[$];
        logic [7:0] xs;
        int n;
        int c;
        int first_c;
        int done_c;
        int done_cnt;
        int last_acc;
        int stall_left;
        logic prev_valid;
        logic prev_ready;
        logic [7:0] prev_data;
        logic [A-1:0] prev_addr;

        n = (len == 0) ? 0 : ((len > DEPTH) ? DEPTH : len);
        xs = 8'h00;
        for (int i = 0; i < n; i++) begin
            exp_q.push_back(mem[(addr + i) % DEPTH]);
            xs = xs ^ mem[(addr + i) % DEPTH];
        end
`ifdef RAM_RD_CHECKSUM_EN
        if (n > 0) exp_q.push_back(xs);
`endif
        c = 0; first_c = -1; done_c = -1; done_cnt = 0; last_acc = -1;
        stall_left = 5; prev_valid = 1'b0; prev_ready = 1'b0;
        prev_data = '0; prev_addr = '0;

        @(negedge clk);
        start = 1'b1;
        start_addr = A'(addr);
        burst_len = (A + 1)'(len);
        tx_ready = (mode == 1) ? ($urandom_range(0, 3) != 0) : 1'b1;

        while (c < 400) begin
            @(negedge clk);
            c++;
            start = 1'b0;
            if (prev_valid && !prev_ready) begin
                check("hold_valid", 32'(tx_valid), 32'd1);
                check("hold_data", 32'(tx_data), 32'(prev_data));
                check("hold_addr", 32'(address_r), 32'(prev_addr));
            end
            if (c == 1) begin
                check("busy_after_start", 32'(busy), 32'd1);
                if (n > 0) check("fetch_addr", 32'(address_r), 32'(addr));
            end
            if (tx_valid && first_c < 0) first_c = c;
            if (done) begin
                done_cnt++;
                if (done_c < 0) done_c = c;
                check("done_valid_low", 32'(tx_valid), 32'd0);
            end
            case (mode)
                1: tx_ready = ($urandom_range(0, 3) != 0);
                2: begin
                    if (tx_valid && got.size() == 1 && stall_left > 0) begin
                        tx_ready = 1'b0;
                        stall_left--;
                    end else begin
                        tx_ready = 1'b1;
                    end
                end
                default: tx_ready = 1'b1;
            endcase
            // Stray starts while streaming must be ignored.
            if (mode == 1 && tx_valid) begin
                start = ($urandom_range(0, 3) == 0);
                start_addr = A'($urandom_range(0, DEPTH - 1));
                burst_len = (A + 1)'($urandom_range(1, 40));
            end
            if (tx_valid && got.size() < n)
                check("addr_track", 32'(address_r), 32'((addr + got.size() + 1) % DEPTH));
            if (tx_valid && tx_ready) begin
                got.push_back(tx_data);
                last_acc = c;
            end
            prev_valid = tx_valid; prev_ready = tx_ready;
            prev_data = tx_data; prev_addr = address_r;
            if (done_c >= 0 && c >= done_c + 2) break;
        end
        start = 1'b0;

        check("beat_count", 32'(got.size()), 32'(exp_q.size()));
        check("data_count", 32'((n > 0 && got.size() > exp_q.size() - n) ? n : got.size()), 32'(exp_count));
        for (int i = 0; i < exp_q.size() && i < got.size(); i++)
            check($sformatf("byte%0d", i), 32'(got[i]), 32'(exp_q[i]));
        check("done_pulses", 32'(done_cnt), 32'd1);
        if (n > 0) begin
            check("first_latency", 32'(first_c), 32'd2);
            check("done_latency", 32'(done_c), 32'(last_acc + 1));
        end else begin
            check("done_latency", 32'(done_c), 32'd1);
            check("no_valid", 32'(first_c), 32'hFFFF_FFFF);
        end
        check("idle_busy", 32'(busy), 32'd0);
        $display("burst addr=%0d len=%0d mode=%0d beats=%0d expected=%0d errors_so_far=%0d",
                 addr, len, mode, got.size(), exp_q.size(), errors);
    endtask

    vec_t tbl[8];

    initial begin
        int acc;
        int bad;

        tbl[0] = '{addr: 4,  len: 3,  mode: 0, exp_count: 3};
        tbl[1] = '{addr: 30, len: 4,  mode: 0, exp_count: 4};
        tbl[2] = '{addr: 0,  len: 5,  mode: 2, exp_count: 5};
        tbl[3] = '{addr: 7,  len: 0,  mode: 0, exp_count: 0};
        tbl[4] = '{addr: 9,  len: 40, mode: 0, exp_count: 32};
        tbl[5] = '{addr: 0,  len: 32, mode: 1, exp_count: 32};
        tbl[6] = '{addr: 17, len: 32, mode: 0, exp_count: 32};
        tbl[7] = '{addr: 31, len: 1,  mode: 1, exp_count: 1};

        for (int i = 0; i < DEPTH; i++) mem[i] = 8'(i + 8'h10);
        rst = 1'b1; start = 1'b0; start_addr = '0; burst_len = '0; tx_ready = 1'b1;

        #1;
        check("rst_valid", 32'(tx_valid), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_addr", 32'(address_r), 32'd0);
        check("rst_data", 32'(tx_data), 32'd0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;

        for (int i = 0; i < 8; i++)
            run_burst(tbl[i].addr, tbl[i].len, tbl[i].mode, tbl[i].exp_count);

`ifdef RAM_RD_CHECKSUM_EN
        mem[0] = 8'hA5; mem[1] = 8'h0F;
        run_burst(0, 2, 0, 2);
        mem[0] = 8'h10; mem[1] = 8'h11;
`endif

        // Reset in the middle of a 5-byte burst after 2 bytes have gone.
        @(negedge clk);
        start = 1'b1; start_addr = 5'd0; burst_len = 6'd5; tx_ready = 1'b1;
        acc = 0;
        for (int c = 0; c < 20 && acc < 2; c++) begin
            @(negedge clk);
            start = 1'b0;
            if (tx_valid && tx_ready) acc++;
        end
        check("abort_reached", 32'(acc), 32'd2);
        @(posedge clk);
        #2 rst = 1'b1;
        #1;
        check("abort_valid", 32'(tx_valid), 32'd0);
        check("abort_busy", 32'(busy), 32'd0);
        check("abort_done", 32'(done), 32'd0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        bad = 0;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            if (tx_valid || done || busy) bad++;
        end
        check("abort_quiet", 32'(bad), 32'd0);
        $display("reset abort after %0d bytes, activity_after=%0d", acc, bad);
        run_burst(3, 5, 0, 5);

        // Randomized bursts over random RAM contents and random back-pressure.
        for (int r = 0; r < 15; r++) begin
            int a;
            int l;
            for (int i = 0; i < DEPTH; i++) mem[i] = 8'($urandom);
            a = $urandom_range(0, DEPTH - 1);
            l = $urandom_range(0, 45);
            run_burst(a, l, 1, (l > DEPTH) ? DEPTH : l);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    // Absolute time bound so the run always ends.
    initial begin
        #2000000;
        $display("FAIL timeout actual=running required=finished");
        $fatal(1, "timeout");
    end

endmodule
